csr_reg: RTL

- Machine-mode CSR file for the RV32I core, at the far end of the writeback CSR path.
- Accepts the CSR write that the MEM/WB pipeline register presents: write enable, 12-bit address and 32-bit data.
- Serves the combinational CSR read for the ID/EX stages.
- Maintains the 64-bit cycle and instret counters, performs trap-entry and mret state updates, and drives trap vector, return PC and interrupt-pending signals to the control unit.

---
 rtl/csr_reg.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/csr_reg.sv
// Machine-mode CSR file for the RV32I core: software CSR writes from writeback,
// combinational CSR reads, 64-bit cycle/instret counters, trap-entry/mret state and interrupt pending.
module csr_reg #(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h40000100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [11:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [11:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        instret_i,
  input  logic        exc_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        ext_irq_i,
  input  logic        tmr_irq_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        irq_pend_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic        r_msie;
  logic        r_mtie;
  logic        r_meie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [63:0] w_mcycle_nxt;
  logic [63:0] w_minstret_nxt;
  logic [31:0] w_rdata_reg;
  logic        w_bypass;
  logic        w_sw_mstatus;
  logic        w_sw_trapregs;

  function automatic logic f_writable(input logic [11:0] addr);
    case (addr)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
      A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: f_writable = 1'b1;
      default:                                      f_writable = 1'b0;
    endcase
  endfunction

  // Value a write would present on readback once WARL fields are applied.
  function automatic logic [31:0] f_wmask(input logic [11:0] addr, input logic [31:0] data);
    case (addr)
      A_MSTATUS:      f_wmask = (data & 32'h0000_0088) | 32'h0000_1800;
      A_MIE:          f_wmask = data & 32'h0000_0888;
      A_MTVEC, A_MEPC: f_wmask = {data[31:2], 2'b00};
      default:        f_wmask = data;
    endcase
  endfunction

  assign w_sw_mstatus  = we_i && (waddr_i == A_MSTATUS) && !exc_i && !mret_i;
  assign w_sw_trapregs = we_i && !exc_i;

  // A high-word write drops the low-word carry; a low-word write freezes the count.
  always_comb begin
    w_mcycle_nxt   = r_mcycle + 64'd1;
    w_minstret_nxt = r_minstret + {63'd0, instret_i};
    if (we_i && waddr_i == A_MCYCLE)
      w_mcycle_nxt = {r_mcycle[63:32], wdata_i};
    else if (we_i && waddr_i == A_MCYCLEH)
      w_mcycle_nxt = {wdata_i, r_mcycle[31:0] + 32'd1};
    if (we_i && waddr_i == A_MINSTRET)
      w_minstret_nxt = {r_minstret[63:32], wdata_i};
    else if (we_i && waddr_i == A_MINSTRETH)
      w_minstret_nxt = {wdata_i, r_minstret[31:0] + {31'd0, instret_i}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_msie         <= 1'b0;
      r_mtie         <= 1'b0;
      r_meie         <= 1'b0;
      r_mtvec        <= 32'd0;
      r_mscratch     <= 32'd0;
      r_mepc         <= 32'd0;
      r_mcause       <= 32'd0;
      r_mtval        <= 32'd0;
      r_mcycle       <= 64'd0;
      r_minstret     <= 64'd0;
    end else begin
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
      if (we_i && waddr_i == A_MIE) begin
        r_msie <= wdata_i[3];
        r_mtie <= wdata_i[7];
        r_meie <= wdata_i[11];
      end
      if (we_i && waddr_i == A_MTVEC)    r_mtvec    <= {wdata_i[31:2], 2'b00};
      if (we_i && waddr_i == A_MSCRATCH) r_mscratch <= wdata_i;
      if (exc_i) begin
        r_mepc         <= {exc_pc_i[31:2], 2'b00};
        r_mcause       <= exc_cause_i;
        r_mtval        <= exc_tval_i;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else begin
        if (mret_i) begin
          r_mstatus_mie  <= r_mstatus_mpie;
          r_mstatus_mpie <= 1'b1;
        end else if (w_sw_mstatus) begin
          r_mstatus_mie  <= wdata_i[3];
          r_mstatus_mpie <= wdata_i[7];
        end
        if (w_sw_trapregs && waddr_i == A_MEPC)   r_mepc   <= {wdata_i[31:2], 2'b00};
        if (w_sw_trapregs && waddr_i == A_MCAUSE) r_mcause <= wdata_i;
        if (w_sw_trapregs && waddr_i == A_MTVAL)  r_mtval  <= wdata_i;
      end
    end
  end

  always_comb begin
    w_rdata_reg = 32'd0;
    case (raddr_i)
      A_MSTATUS:              w_rdata_reg = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
      A_MISA:                 w_rdata_reg = MISA_VAL;
      A_MIE:                  w_rdata_reg = {20'd0, r_meie, 3'd0, r_mtie, 3'd0, r_msie, 3'd0};
      A_MTVEC:                w_rdata_reg = r_mtvec;
      A_MSCRATCH:             w_rdata_reg = r_mscratch;
      A_MEPC:                 w_rdata_reg = r_mepc;
      A_MCAUSE:               w_rdata_reg = r_mcause;
      A_MTVAL:                w_rdata_reg = r_mtval;
      A_MIP:                  w_rdata_reg = {20'd0, ext_irq_i, 3'd0, tmr_irq_i, 7'd0};
      A_MCYCLE, A_CYCLE:      w_rdata_reg = r_mcycle[31:0];
      A_MCYCLEH, A_CYCLEH:    w_rdata_reg = r_mcycle[63:32];
      A_MINSTRET, A_INSTRET:  w_rdata_reg = r_minstret[31:0];
      A_MINSTRETH, A_INSTRETH: w_rdata_reg = r_minstret[63:32];
      A_MHARTID:              w_rdata_reg = HART_ID;
      default:                w_rdata_reg = 32'd0;
    endcase
  end

  assign w_bypass   = we_i && (waddr_i == raddr_i) && f_writable(waddr_i);
  assign rdata_o    = w_bypass ? f_wmask(waddr_i, wdata_i) : w_rdata_reg;
  assign mtvec_o    = r_mtvec;
  assign mepc_o     = r_mepc;
  assign irq_pend_o = r_mstatus_mie & ((r_meie & ext_irq_i) | (r_mtie & tmr_irq_i));

endmodule
